// File: rtl/bram_arbiter_pkg.sv
// Shared types for the two-port block-RAM arbiter: FSM state, the pending-request
// slot layout and the arbitration decision.
package bram_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_slot_t;

    // Returns 1 when the data port takes the shared port this cycle.
    function automatic logic arb_pick_dmem(input logic rr_en, input logic last_imem,
                                           input logic imem_cand, input logic dmem_cand);
        return dmem_cand && (!imem_cand || !rr_en || last_imem);
    endfunction

endpackage

// File: rtl/bram_arbiter_slot.sv
// One pending-request holding register: a load captures the request, a grant clears it.
module bram_arbiter_slot
    import bram_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  wstrb_in,
    output logic        slot_valid,
    output logic [31:0] slot_addr,
    output logic [31:0] slot_wdata,
    output logic [3:0]  slot_wstrb
);

    req_slot_t slot_d, slot_q;

    // Clear wins: a live request granted on the edge it arrives never parks here.
    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            slot_d.valid = 1'b0;
        end else if (load) begin
            slot_d = '{valid: 1'b1, addr: addr_in, wdata: wdata_in, wstrb: wstrb_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_valid = slot_q.valid;
    assign slot_addr  = slot_q.addr;
    assign slot_wdata = slot_q.wdata;
    assign slot_wstrb = slot_q.wstrb;

    overwrite_pending_a: assert property (@(posedge clk) disable iff (!rst)
        !(load && slot_q.valid && !clear));

endmodule

// File: rtl/bram_arbiter.sv
// Two-to-one arbiter between instruction fetch and data port onto one block-RAM port.
// Valid/ready: requesters pulse valid once and wait for the one-cycle ready pulse.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter bit rr_enable = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready,
    output logic        dbg_state
);

    arb_state_t  state_d, state_q;
    logic        last_imem_d, last_imem_q;
    logic        bram_valid_d, bram_valid_q;
    logic        bram_instr_d, bram_instr_q;
    logic [31:0] bram_addr_d, bram_addr_q;
    logic [31:0] bram_wdata_d, bram_wdata_q;
    logic [3:0]  bram_wstrb_d, bram_wstrb_q;

    logic        im_pend, dm_pend;
    logic [31:0] im_addr, dm_addr, im_wdata, dm_wdata;
    logic [3:0]  im_wstrb, dm_wstrb;
    logic        imem_cand, dmem_cand, pick_dmem, grant_ok, issue;
    logic        unused_imem_store;

    bram_arbiter_slot u_imem_slot (
        .clk(clk), .rst(rst), .load(imem_valid), .clear(issue && !pick_dmem),
        .addr_in(imem_addr), .wdata_in(32'h0), .wstrb_in(4'h0),
        .slot_valid(im_pend), .slot_addr(im_addr), .slot_wdata(im_wdata), .slot_wstrb(im_wstrb)
    );

    bram_arbiter_slot u_dmem_slot (
        .clk(clk), .rst(rst), .load(dmem_valid), .clear(issue && pick_dmem),
        .addr_in(dmem_addr), .wdata_in(dmem_wdata), .wstrb_in(dmem_wstrb),
        .slot_valid(dm_pend), .slot_addr(dm_addr), .slot_wdata(dm_wdata), .slot_wstrb(dm_wstrb)
    );

    // Fetch never stores, whatever its slot happens to hold.
    assign unused_imem_store = ^{im_wdata, im_wstrb};

    assign imem_cand = imem_valid || im_pend;
    assign dmem_cand = dmem_valid || dm_pend;
    assign pick_dmem = arb_pick_dmem(rr_enable, last_imem_q, imem_cand, dmem_cand);
    assign grant_ok  = (state_q == ARB_IDLE) || bram_ready;
    assign issue     = grant_ok && (imem_cand || dmem_cand);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (issue) state_d = ARB_WAIT;
            ARB_WAIT: if (bram_ready) state_d = issue ? ARB_WAIT : ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        imem_ready   = (state_q == ARB_WAIT) && bram_ready && bram_instr_q;
        dmem_ready   = (state_q == ARB_WAIT) && bram_ready && !bram_instr_q;
        imem_rdata   = imem_ready ? bram_rdata : 32'h0;
        dmem_rdata   = dmem_ready ? bram_rdata : 32'h0;
        bram_valid_d = issue;
        bram_instr_d = bram_instr_q;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        bram_wstrb_d = bram_wstrb_q;
        last_imem_d  = last_imem_q;
        if (issue) begin
            bram_instr_d = !pick_dmem;
            last_imem_d  = !pick_dmem;
            if (pick_dmem) begin
                bram_addr_d  = dmem_valid ? dmem_addr  : dm_addr;
                bram_wdata_d = dmem_valid ? dmem_wdata : dm_wdata;
                bram_wstrb_d = dmem_valid ? dmem_wstrb : dm_wstrb;
            end else begin
                bram_addr_d  = imem_valid ? imem_addr : im_addr;
                bram_wdata_d = 32'h0;
                bram_wstrb_d = 4'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_imem_q  <= 1'b1;
            bram_valid_q <= 1'b0;
            bram_instr_q <= 1'b0;
            bram_addr_q  <= 32'h0;
            bram_wdata_q <= 32'h0;
            bram_wstrb_q <= 4'h0;
        end else begin
            last_imem_q  <= last_imem_d;
            bram_valid_q <= bram_valid_d;
            bram_instr_q <= bram_instr_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            bram_wstrb_q <= bram_wstrb_d;
        end
    end

    assign bram_valid = bram_valid_q;
    assign bram_instr = bram_instr_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_wstrb = bram_wstrb_q;
    assign dbg_state  = state_q;

endmodule
